lieat_general_fifo_flex: RTL and testbench

Parametrised synchronous FIFO, successor to the single-mode general FIFO used between pipeline stages and for outstanding-instruction tracking. It adds any-depth binary pointers, which supports non-power-of-two depths, plus an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. An optional zero-latency bypass path is selected at compile time. It is a drop-in buffer wherever a valid/ready stage needs elastic storage with back-pressure visibility.

---
 rtl/lieat_general_pkg.sv | 31 +++
 rtl/lieat_general_fifo_ptr.sv | 30 +++
 rtl/lieat_general_fifo_flex.sv | 131 +++++++++++++
 tb/tb_lieat_general_fifo_flex.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_general_pkg.sv
// Shared definitions for the lieat_general FIFO family.
//   clog2     : ceiling log2 used for width derivation.
//   width_for : bits needed to hold 0..n-1, never narrower than one bit.
//   FIFO_BYPASS_EN : compile-time switch driven by macro LIEAT_FIFO_BYPASS_EN
//                    (undefined by default, which leaves the bypass path out).
package lieat_general_pkg;

`ifdef LIEAT_FIFO_BYPASS_EN
    localparam bit FIFO_BYPASS_EN = 1'b1;
`else
    localparam bit FIFO_BYPASS_EN = 1'b0;
`endif

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Field width for values 0..n-1, clamped so degenerate sizes still get one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/lieat_general_fifo_ptr.sv
// Wrapping binary pointer, 0..DP-1, for FIFO depths that need not be powers of two.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset to 0
//   clr : synchronous clear to 0 (flush)
//   en  : advance by one, wrapping DP-1 -> 0
//   ptr : current pointer value
module lieat_general_fifo_ptr
    import lieat_general_pkg::*;
#(
    parameter  int unsigned DP = 8,
    localparam int unsigned PW = width_for(DP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    // Explicit wrap compare so non-power-of-two depths cycle correctly.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(DP - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/lieat_general_fifo_flex.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// flags, synchronous flush and an optional zero-latency bypass path
// (compile-time macro LIEAT_FIFO_BYPASS_EN, off by default).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous discard of all entries
//   i_valid/i_ready/i_data : write side handshake
//   o_valid/o_ready/o_data : read side handshake (o_data masked when MASK=1)
//   count             : entries held, 0..DP
//   empty/full        : count==0 / count==DP
//   almost_full       : count >= AF_LVL
//   almost_empty      : count <= AE_LVL
// DP=0 builds a plain wire passthrough with constant flags.
module lieat_general_fifo_flex
    import lieat_general_pkg::*;
#(
    parameter  int unsigned DP     = 8,
    parameter  int unsigned DW     = 32,
    parameter  int unsigned AF_LVL = (DP > 0) ? DP - 1 : 0,
    parameter  int unsigned AE_LVL = 1,
    parameter  bit          MASK   = 1'b1,
    localparam int unsigned CW     = width_for(DP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty
);

    if (DP == 0) begin : g_wire
        // No storage: handshake and data go straight through.
        assign o_valid      = i_valid;
        assign i_ready      = o_ready;
        assign o_data       = i_data;
        assign count        = '0;
        assign empty        = 1'b1;
        assign full         = 1'b0;
        assign almost_empty = 1'b1;
        assign almost_full  = 1'b0;
    end else begin : g_fifo
        localparam int unsigned PW = width_for(DP);

        logic [DW-1:0] mem [DP];
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic          blk;
        logic          push;
        logic          pop;
        logic          byp_take;
        logic          wr_en;
        logic          rd_en;
        logic [DW-1:0] raw_data;

        // Reset and flush both block any handshake in their cycle.
        assign blk = rst | flush;

        // Flags come only from the registered count.
        assign empty        = (count == '0);
        assign full         = (count == CW'(DP));
        assign almost_full  = (32'(count) >= AF_LVL);
        assign almost_empty = (32'(count) <= AE_LVL);

        // A full FIFO still accepts a write in a cycle that pops.
        assign i_ready = ~blk & (~full | o_ready);
        assign push    = i_valid & i_ready;
        assign pop     = o_valid & o_ready;

        if (FIFO_BYPASS_EN) begin : g_byp
            logic byp_sel;
            // While empty the head is the incoming word itself.
            assign byp_sel  = empty & ~blk;
            assign o_valid  = byp_sel ? i_valid : (~blk & ~empty);
            assign raw_data = byp_sel ? i_data : mem[rptr];
            // Word handed straight to the consumer never touches storage.
            assign byp_take = byp_sel & push & pop;
        end else begin : g_nobyp
            assign o_valid  = ~blk & ~empty;
            assign raw_data = mem[rptr];
            assign byp_take = 1'b0;
        end

        assign wr_en  = push & ~byp_take;
        assign rd_en  = pop & ~byp_take;
        assign o_data = (MASK && !o_valid) ? '0 : raw_data;

        // Data storage, intentionally without reset.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wptr] <= i_data;
            end
        end

        lieat_general_fifo_ptr #(.DP(DP)) u_wptr (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .en  (wr_en),
            .ptr (wptr)
        );

        lieat_general_fifo_ptr #(.DP(DP)) u_rptr (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .en  (rd_en),
            .ptr (rptr)
        );

        // Occupancy: simultaneous read and write leave it unchanged.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                count <= '0;
            end else if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lieat_general_fifo_flex.sv
// Bench for lieat_general_fifo_flex: one DP=4 instance (a) and one DP=3
// instance (b), both DW=8, checked every cycle against a queue model,
// plus directed literal expectations. Honors LIEAT_FIFO_BYPASS_EN.
module tb_lieat_general_fifo_flex;

    typedef struct packed {
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [7:0] cnt;
        logic       em;
        logic       fu;
        logic       af;
        logic       ae;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
    logic [7:0] a_id = 8'h00;
    logic       a_ir, a_ov, a_em, a_fu, a_af, a_ae;
    logic [7:0] a_od;
    logic [2:0] a_cnt;

    logic       b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0;
    logic [7:0] b_id = 8'h00;
    logic       b_ir, b_ov, b_em, b_fu, b_af, b_ae;
    logic [7:0] b_od;
    logic [1:0] b_cnt;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;
    int         npop;
    logic [7:0] pops [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

    lieat_general_fifo_flex #(.DP(4), .DW(8)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
        .o_valid(a_ov), .o_ready(a_or), .o_data(a_od),
        .count(a_cnt), .empty(a_em), .full(a_fu),
        .almost_full(a_af), .almost_empty(a_ae)
    );

    lieat_general_fifo_flex #(.DP(3), .DW(8)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .i_valid(b_iv), .i_ready(b_ir), .i_data(b_id),
        .o_valid(b_ov), .o_ready(b_or), .o_data(b_od),
        .count(b_cnt), .empty(b_em), .full(b_fu),
        .almost_full(b_af), .almost_empty(b_ae)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs from occupancy, head word and current inputs.
    function automatic exp_t model_out(input int dp, input int sz, input logic [7:0] head,
                                       input logic blk, input logic iv, input logic ordy,
                                       input logic [7:0] id);
        exp_t e;
        e.cnt = 8'(sz);
        e.em  = (sz == 0);
        e.fu  = (sz == dp);
        e.af  = (sz >= dp - 1);
        e.ae  = (sz <= 1);
        e.ir  = !blk && (sz < dp || ordy);
        e.ov  = !blk && (sz > 0);
        e.od  = e.ov ? head : 8'h00;
`ifdef LIEAT_FIFO_BYPASS_EN
        if (sz == 0 && !blk) begin
            e.ov = iv;
            e.od = iv ? id : 8'h00;
        end
`endif
        return e;
    endfunction

    function automatic exp_t exp_a();
        return model_out(4, qa.size(), (qa.size() > 0) ? qa[0] : 8'h00,
                         rst | a_flush, a_iv, a_or, a_id);
    endfunction

    function automatic exp_t exp_b();
        return model_out(3, qb.size(), (qb.size() > 0) ? qb[0] : 8'h00,
                         rst | b_flush, b_iv, b_or, b_id);
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        exp_t ea, eb;
        logic pu, po;
        ea = exp_a();
        eb = exp_b();
        if (rst || a_flush) begin
            qa.delete();
        end else begin
            pu = a_iv && ea.ir;
            po = ea.ov && a_or;
            if (!(qa.size() == 0 && pu && po)) begin
                if (po) void'(qa.pop_front());
                if (pu) qa.push_back(a_id);
            end
        end
        if (rst || b_flush) begin
            qb.delete();
        end else begin
            pu = b_iv && eb.ir;
            po = eb.ov && b_or;
            if (!(qb.size() == 0 && pu && po)) begin
                if (po) void'(qb.pop_front());
                if (pu) qb.push_back(b_id);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (chk_en) begin
            ea = exp_a();
            eb = exp_b();
            chk("a_i_ready", 32'(a_ir), 32'(ea.ir));
            chk("a_o_valid", 32'(a_ov), 32'(ea.ov));
            chk("a_o_data", 32'(a_od), 32'(ea.od));
            chk("a_count", 32'(a_cnt), 32'(ea.cnt));
            chk("a_empty", 32'(a_em), 32'(ea.em));
            chk("a_full", 32'(a_fu), 32'(ea.fu));
            chk("a_almost_full", 32'(a_af), 32'(ea.af));
            chk("a_almost_empty", 32'(a_ae), 32'(ea.ae));
            chk("b_i_ready", 32'(b_ir), 32'(eb.ir));
            chk("b_o_valid", 32'(b_ov), 32'(eb.ov));
            chk("b_o_data", 32'(b_od), 32'(eb.od));
            chk("b_count", 32'(b_cnt), 32'(eb.cnt));
            chk("b_empty", 32'(b_em), 32'(eb.em));
            chk("b_full", 32'(b_fu), 32'(eb.fu));
            chk("b_almost_full", 32'(b_af), 32'(eb.af));
            chk("b_almost_empty", 32'(b_ae), 32'(eb.ae));
        end
    end

    initial begin
        nxt();
        chk_en = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_empty", 32'(a_em), 1);
        chk("rst_full", 32'(a_fu), 0);
        chk("rst_o_valid", 32'(a_ov), 0);
        chk("rst_o_data", 32'(a_od), 0);
        chk("rst_almost_empty", 32'(a_ae), 1);
        chk("rst_almost_full", 32'(a_af), 0);
        nxt();
        rst = 1'b0;

        // Fill DP=4 with o_ready low.
        a_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_id = 8'(8'h11 * (i + 1));
            @(negedge clk);
            chk("fill_count", 32'(a_cnt), 32'(i));
            chk("fill_almost_full", 32'(a_af), (i >= 3) ? 1 : 0);
            nxt();
        end
        a_iv = 1'b0;
        @(negedge clk);
        chk("full_count", 32'(a_cnt), 4);
        chk("full_flag", 32'(a_fu), 1);
        chk("full_i_ready", 32'(a_ir), 0);
        chk("full_head", 32'(a_od), 32'h11);
        nxt();

        // Simultaneous push/pop on a full FIFO.
        a_iv = 1'b1; a_id = 8'h55; a_or = 1'b1;
        @(negedge clk);
        chk("fullpp_i_ready", 32'(a_ir), 1);
        chk("fullpp_head", 32'(a_od), 32'h11);
        nxt();
        a_iv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_order", 32'(a_od), 32'(pops[k]));
            chk("drain_count", 32'(a_cnt), 32'(4 - k));
            nxt();
        end
        a_or = 1'b0;
        @(negedge clk);
        chk("drained_empty", 32'(a_em), 1);
        nxt();

        // DP=3: fill, then sustained push/pop pairs, then drain.
        npop = 0;
        for (int i = 0; i < 13; i++) begin
            b_iv = (i < 10);
            b_id = 8'(i);
            b_or = (i >= 3);
            @(negedge clk);
            if (b_ov && b_or) begin
                chk("b_order", 32'(b_od), 32'(npop));
                npop++;
            end
            nxt();
        end
        b_iv = 1'b0; b_or = 1'b0;
        chk("b_pop_total", 32'(npop), 10);

        // Flush at count=3 with a handshake attempted on both sides.
        a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = 8'(i + 1);
            nxt();
        end
        a_flush = 1'b1; a_id = 8'h99; a_or = 1'b1;
        @(negedge clk);
        chk("flush_pre_count", 32'(a_cnt), 3);
        chk("flush_i_ready", 32'(a_ir), 0);
        chk("flush_o_valid", 32'(a_ov), 0);
        nxt();
        a_flush = 1'b0; a_id = 8'hA5; a_or = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(a_cnt), 0);
        chk("flush_empty", 32'(a_em), 1);
        nxt();
        a_iv = 1'b0;
        @(negedge clk);
        chk("post_flush_data", 32'(a_od), 32'hA5);
        chk("post_flush_valid", 32'(a_ov), 1);
        nxt();
        a_or = 1'b1;
        nxt();
        a_or = 1'b0;

        // Reset pulse with two entries held.
        a_iv = 1'b1; a_id = 8'h61;
        nxt();
        a_id = 8'h62;
        nxt();
        a_iv = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", 32'(a_cnt), 2);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_o_valid", 32'(a_ov), 0);
        chk("in_rst_o_data", 32'(a_od), 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_count", 32'(a_cnt), 0);
        chk("rst2_empty", 32'(a_em), 1);
        chk("rst2_o_valid", 32'(a_ov), 0);
        chk("rst2_o_data", 32'(a_od), 0);
        chk("rst2_almost_empty", 32'(a_ae), 1);
        nxt();

`ifdef LIEAT_FIFO_BYPASS_EN
        // Zero-latency pass-through when empty.
        a_iv = 1'b1; a_id = 8'h77; a_or = 1'b1;
        @(negedge clk);
        chk("byp_o_valid", 32'(a_ov), 1);
        chk("byp_o_data", 32'(a_od), 32'h77);
        nxt();
        a_or = 1'b0;
        @(negedge clk);
        chk("byp_count_kept", 32'(a_cnt), 0);
        nxt();
        a_iv = 1'b0;
        @(negedge clk);
        chk("byp_stored_count", 32'(a_cnt), 1);
        chk("byp_stored_data", 32'(a_od), 32'h77);
        nxt();
`else
        // Without bypass the push is visible only one cycle later.
        a_iv = 1'b1; a_id = 8'h77; a_or = 1'b1;
        @(negedge clk);
        chk("nobyp_o_valid", 32'(a_ov), 0);
        nxt();
        a_iv = 1'b0; a_or = 1'b0;
        @(negedge clk);
        chk("nobyp_count", 32'(a_cnt), 1);
        chk("nobyp_o_data", 32'(a_od), 32'h77);
        nxt();
`endif
        a_or = 1'b1;
        nxt();
        a_or = 1'b0;
        @(negedge clk);
        chk("final_empty", 32'(a_em), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
